uart_rx_frame_collector: RTL and testbench

- Standalone serial receive stage placed directly downstream of the apb_uart tx_o line, in place of the current tx_o→rx_i loopback.
- Oversamples the line at 16x, decodes 5–8 bit frames with optional parity and 1/2 stop bits, and buffers received characters with per-character error flags in a FIFO.
- Exposes the FIFO through a valid/ready stream so the simulation top (or a Renode-facing adapter) can check what the DUT transmitted.

---
 rtl/uart_rx_frame_collector.sv | 208 ++++++++++++++++++++
 tb/tb_uart_rx_frame_collector.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame_collector.sv
// 16x-oversampled UART receiver with latched per-frame config and a FWFT character FIFO.
// Each FIFO entry carries the character plus its frame and parity error flags.
module uart_rx_frame_collector #(
    parameter int FifoDepth = 8,
    parameter int DivWidth  = 16
) (
    input  logic                         CLK,
    input  logic                         RSTN,
    input  logic                         rx_i,
    input  logic [DivWidth-1:0]          cfg_div_i,
    input  logic [1:0]                   cfg_bits_i,
    input  logic                         cfg_parity_en_i,
    input  logic                         cfg_parity_odd_i,
    input  logic                         cfg_stop2_i,
    output logic [7:0]                   data_o,
    output logic                         frame_err_o,
    output logic                         parity_err_o,
    output logic                         valid_o,
    input  logic                         ready_i,
    output logic                         overrun_o,
    output logic [$clog2(FifoDepth):0]   level_o
);

    localparam int AW = $clog2(FifoDepth);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t              r_state;
    logic                r_rx_meta;
    logic                r_rx_sync;
    logic                r_rx_prev;
    logic [DivWidth-1:0] r_div_cnt;
    logic [DivWidth-1:0] r_div_m1;
    logic [3:0]          r_tick_cnt;
    logic [2:0]          r_bit_idx;
    logic [7:0]          r_shift;
    logic [1:0]          r_bits_l;
    logic                r_par_en_l;
    logic                r_par_odd_l;
    logic                r_stop2_l;
    logic                r_stop_second;
    logic                r_frame_err;
    logic                r_parity_err;
    logic                r_push;
    logic [9:0]          r_push_entry;

    logic [9:0]          r_mem [FifoDepth];
    logic [AW-1:0]       r_wr_ptr;
    logic [AW-1:0]       r_rd_ptr;
    logic [AW:0]         r_level;

    logic [DivWidth-1:0] w_div_m1;
    logic                w_tick;
    logic                w_start;
    logic                w_mid_start;
    logic                w_mid_bit;
    logic                w_pop;
    logic                w_full;
    logic                w_wr;
    logic [9:0]          w_head;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= rx_i;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    assign w_div_m1    = (cfg_div_i == '0) ? '0 : cfg_div_i - DivWidth'(1);
    assign w_tick      = (r_state != S_IDLE) && (r_div_cnt == '0);
    // A falling edge is required, so a line stuck low after a break cannot re-arm.
    assign w_start     = (r_state == S_IDLE) && !r_push && r_rx_prev && !r_rx_sync;
    assign w_mid_start = w_tick && (r_tick_cnt == 4'd7);
    assign w_mid_bit   = w_tick && (r_tick_cnt == 4'd15);

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_state       <= S_IDLE;
            r_div_cnt     <= '0;
            r_div_m1      <= '0;
            r_tick_cnt    <= '0;
            r_bit_idx     <= '0;
            r_shift       <= '0;
            r_bits_l      <= '0;
            r_par_en_l    <= 1'b0;
            r_par_odd_l   <= 1'b0;
            r_stop2_l     <= 1'b0;
            r_stop_second <= 1'b0;
            r_frame_err   <= 1'b0;
            r_parity_err  <= 1'b0;
            r_push        <= 1'b0;
            r_push_entry  <= '0;
        end else begin
            r_push <= 1'b0;
            if (w_start) begin
                r_div_cnt <= w_div_m1;
            end else if (r_state != S_IDLE) begin
                r_div_cnt <= (r_div_cnt == '0) ? r_div_m1 : r_div_cnt - DivWidth'(1);
            end
            if (w_tick) begin
                r_tick_cnt <= r_tick_cnt + 4'd1;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state       <= S_START;
                        r_tick_cnt    <= '0;
                        r_bit_idx     <= '0;
                        r_shift       <= '0;
                        r_frame_err   <= 1'b0;
                        r_parity_err  <= 1'b0;
                        r_stop_second <= 1'b0;
                        r_div_m1      <= w_div_m1;
                        r_bits_l      <= cfg_bits_i;
                        r_par_en_l    <= cfg_parity_en_i;
                        r_par_odd_l   <= cfg_parity_odd_i;
                        r_stop2_l     <= cfg_stop2_i;
                    end
                end
                S_START: begin
                    if (w_mid_start) begin
                        r_tick_cnt <= '0;
                        r_state    <= r_rx_sync ? S_IDLE : S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_mid_bit) begin
                        r_shift[r_bit_idx] <= r_rx_sync;
                        r_bit_idx          <= r_bit_idx + 3'd1;
                        if (r_bit_idx == {1'b1, r_bits_l}) begin
                            r_state <= r_par_en_l ? S_PARITY : S_STOP;
                        end
                    end
                end
                S_PARITY: begin
                    if (w_mid_bit) begin
                        r_parity_err <= ((^r_shift) ^ r_rx_sync) != r_par_odd_l;
                        r_state      <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (w_mid_bit) begin
                        if (r_stop2_l && !r_stop_second) begin
                            r_stop_second <= 1'b1;
                            r_frame_err   <= r_frame_err | !r_rx_sync;
                        end else begin
                            r_state      <= S_IDLE;
                            r_push       <= 1'b1;
                            r_push_entry <= {r_parity_err, r_frame_err | !r_rx_sync, r_shift};
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign w_pop  = (r_level != '0) && ready_i;
    assign w_full = (r_level == (AW+1)'(FifoDepth));
    // A pop in the same cycle frees the slot, so a push on a full FIFO still lands.
    assign w_wr   = r_push && (!w_full || w_pop);

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_wr && !w_pop) begin
                r_level <= r_level + (AW+1)'(1);
            end else if (!w_wr && w_pop) begin
                r_level <= r_level - (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= r_push_entry;
        end
    end

    assign w_head       = r_mem[r_rd_ptr];
    assign valid_o      = (r_level != '0);
    assign data_o       = valid_o ? w_head[7:0] : 8'h00;
    assign frame_err_o  = valid_o & w_head[8];
    assign parity_err_o = valid_o & w_head[9];
    assign overrun_o    = r_push && w_full && !w_pop;
    assign level_o      = r_level;

endmodule

// File: tb/tb_uart_rx_frame_collector.sv
// Directed bench for uart_rx_frame_collector: serial frames driven bit by bit,
// outputs compared against hand-computed characters, flags and FIFO levels.
module tb_uart_rx_frame_collector;

    logic        CLK = 1'b0;
    logic        RSTN;
    logic        rx_i = 1'b1;
    logic [15:0] cfg_div_i = 16'd4;
    logic [1:0]  cfg_bits_i = 2'd3;
    logic        cfg_parity_en_i = 1'b0;
    logic        cfg_parity_odd_i = 1'b0;
    logic        cfg_stop2_i = 1'b0;
    logic [7:0]  data_o;
    logic        frame_err_o;
    logic        parity_err_o;
    logic        valid_o;
    logic        ready_i = 1'b0;
    logic        overrun_o;
    logic [3:0]  level_o;

    int checks   = 0;
    int failures = 0;
    int ov_cnt   = 0;
    int g_div    = 4;

    uart_rx_frame_collector #(.FifoDepth(8), .DivWidth(16)) dut (
        .CLK              (CLK),
        .RSTN             (RSTN),
        .rx_i             (rx_i),
        .cfg_div_i        (cfg_div_i),
        .cfg_bits_i       (cfg_bits_i),
        .cfg_parity_en_i  (cfg_parity_en_i),
        .cfg_parity_odd_i (cfg_parity_odd_i),
        .cfg_stop2_i      (cfg_stop2_i),
        .data_o           (data_o),
        .frame_err_o      (frame_err_o),
        .parity_err_o     (parity_err_o),
        .valid_o          (valid_o),
        .ready_i          (ready_i),
        .overrun_o        (overrun_o),
        .level_o          (level_o)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) if (overrun_o === 1'b1) ov_cnt++;

    task automatic send_bit(input logic b);
        rx_i = b;
        repeat (16 * g_div) @(negedge CLK);
    endtask

    task automatic send_frame(input logic [7:0] d, input int nbits, input logic par_en,
                              input logic par_bit, input logic stop_a, input logic two_stop,
                              input logic stop_b);
        send_bit(1'b0);
        for (int i = 0; i < nbits; i++) send_bit(d[i]);
        if (par_en) send_bit(par_bit);
        send_bit(stop_a);
        if (two_stop) send_bit(stop_b);
        rx_i = 1'b1;
    endtask

    task automatic pop_one();
        ready_i = 1'b1;
        @(negedge CLK);
        ready_i = 1'b0;
    endtask

    // {valid, parity_err, frame_err, data, level}
    task automatic test_reset();
        RSTN = 1'b1;
        #2 RSTN = 1'b0;
        repeat (3) @(negedge CLK);
        checks++;
        if ({valid_o, parity_err_o, frame_err_o, data_o, level_o, overrun_o} !== 16'h0000) begin
            failures++;
            $display("FAIL reset_outputs got %h exp 0000",
                     {valid_o, parity_err_o, frame_err_o, data_o, level_o, overrun_o});
        end
        RSTN = 1'b1;
        repeat (10) @(negedge CLK);
        checks++;
        if ({valid_o, level_o} !== 5'h00) begin
            failures++;
            $display("FAIL idle_after_reset got %h exp 00", {valid_o, level_o});
        end
    endtask

    task automatic test_8n1();
        g_div = 4; cfg_div_i = 16'd4; cfg_bits_i = 2'd3;
        cfg_parity_en_i = 1'b0; cfg_stop2_i = 1'b0;
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        repeat (16) @(negedge CLK);
        checks++;
        if ({valid_o, parity_err_o, frame_err_o, data_o, level_o} !== {3'b100, 8'hA5, 4'd1}) begin
            failures++;
            $display("FAIL 8n1_a5 got %h exp %h",
                     {valid_o, parity_err_o, frame_err_o, data_o, level_o}, {3'b100, 8'hA5, 4'd1});
        end
        pop_one();
        checks++;
        if ({valid_o, data_o, level_o} !== 13'h0000) begin
            failures++;
            $display("FAIL 8n1_pop got %h exp 0000", {valid_o, data_o, level_o});
        end
    endtask

    task automatic test_parity();
        g_div = 3; cfg_div_i = 16'd3; cfg_bits_i = 2'd0;
        cfg_parity_en_i = 1'b1; cfg_parity_odd_i = 1'b0;
        send_frame(8'h13, 5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        repeat (16) @(negedge CLK);
        checks++;
        if ({valid_o, parity_err_o, frame_err_o, data_o} !== {3'b100, 8'h13}) begin
            failures++;
            $display("FAIL parity_good got %h exp %h",
                     {valid_o, parity_err_o, frame_err_o, data_o}, {3'b100, 8'h13});
        end
        pop_one();
        send_frame(8'h13, 5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        repeat (16) @(negedge CLK);
        checks++;
        if ({valid_o, parity_err_o, frame_err_o, data_o} !== {3'b110, 8'h13}) begin
            failures++;
            $display("FAIL parity_bad got %h exp %h",
                     {valid_o, parity_err_o, frame_err_o, data_o}, {3'b110, 8'h13});
        end
        pop_one();
        cfg_parity_odd_i = 1'b1;
        send_frame(8'h13, 5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        repeat (16) @(negedge CLK);
        checks++;
        if ({valid_o, parity_err_o, frame_err_o, data_o} !== {3'b100, 8'h13}) begin
            failures++;
            $display("FAIL parity_odd got %h exp %h",
                     {valid_o, parity_err_o, frame_err_o, data_o}, {3'b100, 8'h13});
        end
        pop_one();
        cfg_parity_en_i = 1'b0; cfg_parity_odd_i = 1'b0;
    endtask

    task automatic test_stop2_break();
        g_div = 4; cfg_div_i = 16'd4; cfg_bits_i = 2'd3; cfg_stop2_i = 1'b1;
        send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        repeat (16) @(negedge CLK);
        checks++;
        if ({valid_o, parity_err_o, frame_err_o, data_o, level_o} !== {3'b101, 8'h3C, 4'd1}) begin
            failures++;
            $display("FAIL stop2_low got %h exp %h",
                     {valid_o, parity_err_o, frame_err_o, data_o, level_o}, {3'b101, 8'h3C, 4'd1});
        end
        pop_one();
        send_frame(8'h00, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        rx_i = 1'b0;
        repeat (32 * g_div) @(negedge CLK);
        rx_i = 1'b1;
        repeat (32 * g_div) @(negedge CLK);
        checks++;
        if ({valid_o, parity_err_o, frame_err_o, data_o, level_o} !== {3'b101, 8'h00, 4'd1}) begin
            failures++;
            $display("FAIL break got %h exp %h",
                     {valid_o, parity_err_o, frame_err_o, data_o, level_o}, {3'b101, 8'h00, 4'd1});
        end
        pop_one();
        cfg_stop2_i = 1'b0;
        send_frame(8'h55, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        repeat (16) @(negedge CLK);
        checks++;
        if ({valid_o, parity_err_o, frame_err_o, data_o, level_o} !== {3'b100, 8'h55, 4'd1}) begin
            failures++;
            $display("FAIL after_break got %h exp %h",
                     {valid_o, parity_err_o, frame_err_o, data_o, level_o}, {3'b100, 8'h55, 4'd1});
        end
        pop_one();
    endtask

    task automatic test_glitch();
        g_div = 4; cfg_div_i = 16'd4;
        rx_i = 1'b0;
        repeat (3) @(negedge CLK);
        rx_i = 1'b1;
        repeat (160) @(negedge CLK);
        checks++;
        if ({valid_o, level_o} !== 5'h00) begin
            failures++;
            $display("FAIL glitch_level got %h exp 00", {valid_o, level_o});
        end
        send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        repeat (16) @(negedge CLK);
        checks++;
        if ({valid_o, parity_err_o, frame_err_o, data_o, level_o} !== {3'b100, 8'h5A, 4'd1}) begin
            failures++;
            $display("FAIL glitch_then_frame got %h exp %h",
                     {valid_o, parity_err_o, frame_err_o, data_o, level_o}, {3'b100, 8'h5A, 4'd1});
        end
        pop_one();
    endtask

    task automatic test_overrun();
        int base;
        g_div = 4; cfg_div_i = 16'd4; cfg_bits_i = 2'd3;
        ready_i = 1'b0;
        base = ov_cnt;
        for (int i = 1; i <= 8; i++) send_frame(8'(i), 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        repeat (16) @(negedge CLK);
        checks++;
        if ({level_o, 8'(ov_cnt - base)} !== {4'd8, 8'd0}) begin
            failures++;
            $display("FAIL fill_eight got level=%0d ovr=%0d exp level=8 ovr=0", level_o, ov_cnt - base);
        end
        send_frame(8'h09, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        repeat (16) @(negedge CLK);
        checks++;
        if ({level_o, data_o, 8'(ov_cnt - base)} !== {4'd8, 8'h01, 8'd1}) begin
            failures++;
            $display("FAIL overrun got level=%0d head=%h ovr=%0d exp level=8 head=01 ovr=1",
                     level_o, data_o, ov_cnt - base);
        end
        for (int i = 1; i <= 8; i++) begin
            checks++;
            if ({valid_o, data_o} !== {1'b1, 8'(i)}) begin
                failures++;
                $display("FAIL drain_%0d got %h exp %h", i, {valid_o, data_o}, {1'b1, 8'(i)});
            end
            pop_one();
        end
        checks++;
        if ({valid_o, level_o} !== 5'h00) begin
            failures++;
            $display("FAIL drain_empty got %h exp 00", {valid_o, level_o});
        end
    endtask

    task automatic test_reset_mid();
        g_div = 4; cfg_div_i = 16'd4; cfg_bits_i = 2'd3;
        send_frame(8'h11, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        repeat (16) @(negedge CLK);
        checks++;
        if ({valid_o, data_o} !== {1'b1, 8'h11}) begin
            failures++;
            $display("FAIL pre_reset got %h exp %h", {valid_o, data_o}, {1'b1, 8'h11});
        end
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        rx_i = 1'b1;
        repeat (8 * g_div) @(negedge CLK);
        RSTN = 1'b0;
        #1;
        checks++;
        if ({valid_o, parity_err_o, frame_err_o, data_o, level_o, overrun_o} !== 16'h0000) begin
            failures++;
            $display("FAIL mid_reset got %h exp 0000",
                     {valid_o, parity_err_o, frame_err_o, data_o, level_o, overrun_o});
        end
        repeat (4) @(negedge CLK);
        RSTN = 1'b1;
        repeat (20) @(negedge CLK);
        send_frame(8'h7E, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        repeat (16) @(negedge CLK);
        checks++;
        if ({valid_o, parity_err_o, frame_err_o, data_o, level_o} !== {3'b100, 8'h7E, 4'd1}) begin
            failures++;
            $display("FAIL after_reset got %h exp %h",
                     {valid_o, parity_err_o, frame_err_o, data_o, level_o}, {3'b100, 8'h7E, 4'd1});
        end
        pop_one();
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_parity();
        test_stop2_break();
        test_glitch();
        test_overrun();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
